// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI register-file responder.
//   - state_e        : protocol FSM states
//   - CMD_*          : command bytes
//   - ADDR_*         : special register addresses
//   - SOFT_RST_KEY   : value that triggers a register-file soft reset
//   - DEVID*         : fixed device-ID register contents
//   - spi_writable() : true when an address accepts SPI writes
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_IGNORE
   } state_e;

   localparam logic [7:0] CMD_WRITE      = 8'h0A;
   localparam logic [7:0] CMD_READ       = 8'h0B;

   localparam logic [7:0] ADDR_DEVID0    = 8'h00;
   localparam logic [7:0] ADDR_DEVID1    = 8'h01;
   localparam logic [7:0] ADDR_XDATA     = 8'h08;
   localparam logic [7:0] ADDR_SOFT_RST  = 8'h1F;
   localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

   localparam logic [7:0] SOFT_RST_KEY   = 8'h52;
   localparam logic [7:0] DEVID0         = 8'hAD;
   localparam logic [7:0] DEVID1         = 8'h1D;

   // Read-only and write-only-command locations never take SPI data directly.
   function automatic logic spi_writable(input logic [7:0] a);
      return !(a == ADDR_DEVID0 || a == ADDR_DEVID1 ||
               a == ADDR_XDATA  || a == ADDR_SOFT_RST);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep flop synchroniser for one asynchronous input.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronised output (RST_VAL while in reset)
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Truncating cast drops the oldest sample; also valid for STAGES == 1.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= {STAGES{RST_VAL}};
      else     sync_q <= STAGES'({sync_q, d_i});
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 responder in front of a 2^ADDR_W byte register file.
//   clk, rst             : system clock, synchronous active-high reset
//   sclk, cs, mosi       : asynchronous SPI inputs (cs active low)
//   miso, miso_oe        : serial read data and its drive enable
//   sample_in/_valid     : loads the X-axis sample register (0x08)
//   power_ctl            : live contents of register 0x2D
//   soft_rst_pulse       : one-clk pulse after a soft-reset write commits
//   cmd_err              : one-clk pulse on an unknown command byte
// Build option: define SPI_RESPONDER_AUTOINC_EN to advance the address after
// every data byte; otherwise bursts stay on the addressed register.
module spi_responder
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   output logic [7:0] power_ctl,
   output logic       soft_rst_pulse,
   output logic       cmd_err
);

`ifdef SPI_RESPONDER_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   localparam int NREGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] IDX_XDATA = ADDR_XDATA[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] IDX_POWER = ADDR_POWER_CTL[ADDR_W-1:0];

   logic sclk_s, cs_s, mosi_s;
   logic sclk_prev_q, cs_prev_q;
   logic sclk_rise, sclk_fall, cs_fall;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d_i(cs), .q_o(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s));

   assign sclk_rise =  sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s &  sclk_prev_q;
   assign cs_fall   = ~cs_s   &  cs_prev_q;

   state_e            state_q, state_d;
   logic [2:0]        bit_cnt_q;
   logic [7:0]        rx_q, rx_byte;
   logic              byte_done;
   logic              is_rd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        addr8;
   logic              wr_pend_q;
   logic [7:0]        wr_data_q;
   logic              ld_pend_q;
   logic [7:0]        tx_q;
   logic [7:0]        rd_data;
   logic              cmd_err_q, cmd_err_d;
   logic              soft_rst_q;
   logic [7:0]        regs_q [NREGS];

   // Byte as it will stand after this rising edge's bit is shifted in.
   assign rx_byte   = {rx_q[6:0], mosi_s};
   assign byte_done = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
   assign addr8     = 8'(addr_q);

   always_comb begin
      state_d   = state_q;
      cmd_err_d = 1'b0;
      if (cs_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_CMD;
            ST_CMD: if (byte_done) begin
               if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                  state_d = ST_ADDR;
               end else begin
                  state_d   = ST_IGNORE;
                  cmd_err_d = 1'b1;
               end
            end
            ST_ADDR: if (byte_done) state_d = ST_DATA;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (addr8)
         ADDR_DEVID0:   rd_data = DEVID0;
         ADDR_DEVID1:   rd_data = DEVID1;
         ADDR_SOFT_RST: rd_data = 8'h00;
         default:       rd_data = regs_q[addr_q];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         is_rd_q     <= 1'b0;
         addr_q      <= '0;
         wr_pend_q   <= 1'b0;
         wr_data_q   <= '0;
         ld_pend_q   <= 1'b0;
         tx_q        <= '0;
         cmd_err_q   <= 1'b0;
         soft_rst_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         cmd_err_q   <= cmd_err_d;
         soft_rst_q  <= 1'b0;

         // Bit framing; leaving IDLE always starts on a clean byte boundary.
         if (state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
            ld_pend_q <= 1'b0;
            tx_q      <= '0;
         end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            rx_q      <= rx_byte;
         end

         if (state_q == ST_CMD && byte_done) is_rd_q <= (rx_byte == CMD_READ);
         if (state_q == ST_ADDR && byte_done) addr_q <= rx_byte[ADDR_W-1:0];

         // A read needs the next byte ready at the first falling edge after
         // the previous byte (address or data) finishes.
         if ((state_q == ST_ADDR || state_q == ST_DATA) && byte_done && is_rd_q)
            ld_pend_q <= 1'b1;

         if (state_q == ST_DATA && byte_done && !is_rd_q) begin
            wr_pend_q <= 1'b1;
            wr_data_q <= rx_byte;
         end

         // Commit stage runs regardless of cs so a finished byte survives an
         // immediate deselect.
         if (wr_pend_q) begin
            wr_pend_q <= 1'b0;
            if (addr8 == ADDR_SOFT_RST) begin
               if (wr_data_q == SOFT_RST_KEY) begin
                  soft_rst_q <= 1'b1;
                  for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
               end
            end else if (spi_writable(addr8)) begin
               regs_q[addr_q] <= wr_data_q;
            end
            if (AUTOINC) addr_q <= addr_q + 1'b1;
         end

         if (state_q == ST_DATA && is_rd_q && sclk_fall) begin
            if (ld_pend_q) begin
               tx_q      <= rd_data;
               ld_pend_q <= 1'b0;
               if (AUTOINC) addr_q <= addr_q + 1'b1;
            end else begin
               tx_q <= {tx_q[6:0], 1'b0};
            end
         end

         // Last so a new sample wins over a soft reset in the same cycle; the
         // TX load above already captured the old value.
         if (sample_valid) regs_q[IDX_XDATA] <= sample_in;
      end
   end

   assign miso           = (state_q == ST_DATA && is_rd_q) ? tx_q[7] : 1'b0;
   assign miso_oe        = ~cs_s;
   assign power_ctl      = regs_q[IDX_POWER];
   assign soft_rst_pulse = soft_rst_q;
   assign cmd_err        = cmd_err_q;

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed and randomized SPI transactions against a
// transaction-level register-file model.
module tb_spi_responder;

   localparam int SYNC = 2;
   localparam int HALF = 10;   // sclk half period in clk cycles (5 MHz)
`ifdef SPI_RESPONDER_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] sample_in = 8'h00;
   logic       miso, miso_oe, soft_rst_pulse, cmd_err;
   logic [7:0] power_ctl;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int n_cmd_err = 0, n_soft = 0;
   logic [7:0] txb [16];
   logic [7:0] rxb [16];
   logic [7:0] mem [64];
   logic       oe_mid;

   spi_responder #(.SYNC_STAGES(SYNC), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .sample_in(sample_in),
      .sample_valid(sample_valid), .power_ctl(power_ctl),
      .soft_rst_pulse(soft_rst_pulse), .cmd_err(cmd_err));

   always #5 clk = ~clk;

   // High-cycle counters; a one-clk pulse adds exactly one.
   always @(negedge clk) begin
      if (cmd_err) n_cmd_err++;
      if (soft_rst_pulse) n_soft++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---- reference model: register map semantics at transaction level ----
   function automatic logic [7:0] m_rd(input int a);
      case (a)
         8'h00:   return 8'hAD;
         8'h01:   return 8'h1D;
         8'h1F:   return 8'h00;
         default: return mem[a];
      endcase
   endfunction

   task automatic m_wr(input int a, input logic [7:0] d);
      if (a == 8'h1F) begin
         if (d == 8'h52) foreach (mem[i]) mem[i] = 8'h00;
      end else if (a != 8'h00 && a != 8'h01 && a != 8'h08) begin
         mem[a] = d;
      end
   endtask

   // Mode-0 master: mosi changes after sclk falls, miso sampled just before
   // the rise. inj_bit marks the bit whose lead-in coincides with a TX load;
   // a 0x11 sample strobe is placed on exactly that load cycle.
   task automatic xfer(input int nbits, input int inj_bit);
      foreach (rxb[i]) rxb[i] = 8'h00;
      @(negedge clk);
      cs = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         mosi = txb[b/8][7-(b%8)];
         for (int c = 1; c <= HALF; c++) begin
            @(negedge clk);
            if (b == inj_bit && c == SYNC) begin
               sample_in = 8'h11; sample_valid = 1'b1;
            end else if (b == inj_bit && c == SYNC + 1) begin
               sample_valid = 1'b0;
            end
         end
         rxb[b/8][7-(b%8)] = miso;
         if (b == 0) oe_mid = miso_oe;
         sclk = 1'b1;
         wait_clks(HALF);
         sclk = 1'b0;
      end
      wait_clks(HALF);
      cs = 1'b1;
      wait_clks(2 * HALF);
   endtask

   task automatic wr_burst(input int a, input int n);
      int ad;
      txb[0] = 8'h0A;
      txb[1] = {2'($urandom_range(0, 3)), 6'(a)};
      xfer(8 * (n + 2), -1);
      ad = a;
      for (int i = 0; i < n; i++) begin
         m_wr(ad, txb[2+i]);
         if (AUTOINC) ad = (ad + 1) % 64;
      end
   endtask

   task automatic rd_burst(input int a, input int n, input int inj_bit);
      int ad;
      txb[0] = 8'h0B;
      txb[1] = {2'($urandom_range(0, 3)), 6'(a)};
      for (int i = 2; i < 16; i++) txb[i] = 8'($urandom);
      xfer(8 * (n + 2), inj_bit);
      ad = a;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("read_0x%02h", ad), rxb[2+i], m_rd(ad));
         if (AUTOINC) ad = (ad + 1) % 64;
      end
   endtask

   initial begin
      int c0, s0, a, n;
      foreach (mem[i]) mem[i] = 8'h00;

      // reset state
      wait_clks(5);
      chk("rst_miso", {7'd0, miso}, 8'd0);
      chk("rst_miso_oe", {7'd0, miso_oe}, 8'd0);
      chk("rst_soft_pulse", {7'd0, soft_rst_pulse}, 8'd0);
      chk("rst_cmd_err", {7'd0, cmd_err}, 8'd0);
      chk("rst_power_ctl", power_ctl, 8'h00);
      rst = 1'b0;
      wait_clks(5);

      // write burst
      txb[2] = 8'h02;
      wr_burst(8'h2D, 1);
      chk("write_power_ctl", power_ctl, 8'h02);

      // read burst from the device-ID registers
      rd_burst(8'h00, 2, -1);
      chk("rd_cmd_byte_miso", rxb[0], 8'h00);
      chk("rd_addr_byte_miso", rxb[1], 8'h00);
      chk("devid_byte3", rxb[2], 8'hAD);
      chk("devid_byte4", rxb[3], AUTOINC ? 8'h1D : 8'hAD);
      chk("miso_oe_active", {7'd0, oe_mid}, 8'd1);
      chk("miso_oe_idle", {7'd0, miso_oe}, 8'd0);

      // sample register, then a sample strobe on the TX load cycle
      sample_in = 8'h5C; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      mem[8] = 8'h5C;
      rd_burst(8'h08, 1, -1);
      chk("sample_read", rxb[2], 8'h5C);
      sample_in = 8'h77; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      mem[8] = 8'h77;
      rd_burst(8'h08, 1, 16);
      chk("sample_collide_old", rxb[2], 8'h77);
      mem[8] = 8'h11;
      rd_burst(8'h08, 1, -1);
      chk("sample_collide_new", rxb[2], 8'h11);

      // soft reset
      txb[2] = 8'h08;
      wr_burst(8'h2D, 1);
      chk("pre_soft_power_ctl", power_ctl, 8'h08);
      txb[2] = 8'h51;
      wr_burst(8'h1F, 1);
      chk("soft_wrong_key", power_ctl, 8'h08);
      s0 = n_soft;
      txb[2] = 8'h52;
      wr_burst(8'h1F, 1);
      chk("soft_pulse_cycles", 8'(n_soft - s0), 8'd1);
      chk("soft_power_ctl", power_ctl, 8'h00);
      rd_burst(8'h08, 1, -1);

      // unknown command
      txb[2] = 8'h33;
      wr_burst(8'h2D, 1);
      c0 = n_cmd_err;
      txb[0] = 8'h0C; txb[1] = 8'h2D; txb[2] = 8'hFF;
      xfer(24, -1);
      chk("cmd_err_cycles", 8'(n_cmd_err - c0), 8'd1);
      chk("bad_cmd_power_ctl", power_ctl, 8'h33);

      // abort mid data byte, then a normal transaction
      txb[0] = 8'h0A; txb[1] = 8'h2D; txb[2] = 8'hA5;
      xfer(20, -1);
      chk("abort_power_ctl", power_ctl, 8'h33);
      txb[2] = 8'h44;
      wr_burst(8'h2D, 1);
      chk("after_abort_power_ctl", power_ctl, 8'h44);

      // read-only discard and address wrap
      txb[2] = 8'h99;
      wr_burst(8'h01, 1);
      txb[2] = 8'h77; txb[3] = 8'h66;
      wr_burst(8'h3F, 2);
      rd_burst(8'h3F, 2, -1);
      rd_burst(8'h00, 2, -1);

      // randomized bursts
      for (int it = 0; it < 10; it++) begin
         a = int'($urandom_range(0, 63));
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) txb[2+i] = 8'($urandom);
         wr_burst(a, n);
         rd_burst(a, n, -1);
         rd_burst(int'($urandom_range(0, 63)), 2, -1);
      end
      chk("final_power_ctl", power_ctl, mem[8'h2D]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in each synchroniser on sclk, cs and mosi.
REQ-002 The block SHALL have parameter ADDR_W, default 6, meaning the register-file address width (64 bytes).
REQ-003 clk  in  1  system clock (100 MHz); all logic on rising edge; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sclk  in  1  SPI serial clock from the master, asynchronous, mode 0 (CPOL=0, CPHA=0), at most clk/8.
REQ-006 cs  in  1  chip select, active low, asynchronous.
REQ-007 mosi  in  1  serial data from the master, MSB first.
REQ-008 miso  out  1  serial data to the master, MSB first.
REQ-009 miso_oe  out  1  miso drive enable; high only while cs is low.
REQ-010 sample_in  in  8  new X-axis sample.
REQ-011 sample_valid  in  1  single-cycle strobe that loads sample_in into register 0x08.
REQ-012 power_ctl  out  8  current value of register 0x2D.
REQ-013 soft_rst_pulse  out  1  one-clk pulse when a soft reset is committed.
REQ-014 cmd_err  out  1  one-clk pulse when an unknown command byte is received.

Function
REQ-015 sclk, cs and mosi SHALL each pass through a SYNC_STAGES synchroniser, and sclk edges SHALL be detected from the last two synchronised samples.
REQ-016 The FSM states SHALL be:
- IDLE -> CMD on synchronised cs falling.
- CMD -> ADDR after 8 bits if the byte is 0x0A (write) or 0x0B (read); otherwise CMD -> IGNORE with cmd_err pulsed.
- ADDR -> DATA after 8 bits.
- DATA remains in DATA for every following byte.
- Any state -> IDLE on synchronised cs high.
REQ-017 mosi SHALL be sampled on each detected sclk rising edge, and a byte SHALL be complete on its 8th rising edge.
REQ-018 The address byte SHALL use bits [ADDR_W-1:0] only; the upper bits SHALL be ignored.
REQ-019 For a write, each completed data byte SHALL be committed to the current address one clk after its 8th rising edge, and the address SHALL then advance.
REQ-020 For a read, the register at the current address SHALL be latched into the TX shift register on the falling edge that follows the 8th rising edge of the preceding byte.
- Its MSB SHALL be on miso at that falling edge.
- miso SHALL shift once on every subsequent falling edge.
- The address SHALL advance after each byte loaded.
REQ-021 Outside the DATA state of a read, miso SHALL be 0.
REQ-022 Register map:
- 0x00 = 0xAD, read-only.
- 0x01 = 0x1D, read-only.
- 0x08 = XDATA, read-only over SPI, written by sample_valid.
- 0x1F = SOFT_RESET, write-only; reads return 0x00.
- 0x2D = POWER_CTL, read/write, default 0x00.
- All other addresses: read/write, default 0x00.
REQ-023 SPI writes to read-only addresses SHALL be discarded silently.
REQ-024 A write of 0x52 to 0x1F SHALL restore all register defaults and pulse soft_rst_pulse one clk after the commit; other values written to 0x1F SHALL be ignored.
REQ-025 When sample_valid coincides with a TX load of 0x08, the TX shift register SHALL take the old value, and register 0x08 SHALL take sample_in.
REQ-026 When cs rises mid-byte, the partial byte SHALL be discarded, completed writes SHALL be kept, and the FSM SHALL return to IDLE within SYNC_STAGES+2 clk.
REQ-027 The address SHALL wrap from 2^ADDR_W-1 to 0.
REQ-028 power_ctl SHALL be driven directly from register 0x2D with no added latency.

Reset
REQ-029 While rst is high, the block SHALL hold the FSM in IDLE and restore all registers to their defaults.
REQ-030 While rst is high, miso, miso_oe, soft_rst_pulse, cmd_err and power_ctl SHALL be 0, and the synchroniser flops SHALL hold cs=1 and sclk=0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction, and no new transaction SHALL start until a fresh cs falling edge is detected after rst deasserts.

Configuration
REQ-032 With SPI_RESPONDER_AUTOINC_EN defined, the address SHALL increment after each data byte; without it, the address SHALL stay fixed for the whole burst, so repeated reads return the same register and repeated writes overwrite it.

Structure
REQ-033 A package spi_pkg SHALL hold:
- the FSM state enum;
- the command constants CMD_WRITE=0x0A and CMD_READ=0x0B;
- the address constants for 0x00, 0x01, 0x08, 0x1F and 0x2D;
- SOFT_RST_KEY=0x52;
- the DEVID values.
REQ-034 The block SHALL contain one sub-module, spi_sync, which is an SYNC_STAGES-deep synchroniser with a reset value parameter and is instantiated three times.

Verification
REQ-035 Write burst: cs low, send 0x0A 0x2D 0x02 at sclk=5 MHz -> power_ctl=0x02 within 2 clk of the 24th sclk rising edge.
REQ-036 Read burst: send 0x0B 0x00 0x00 0x00 -> miso returns 0xAD then 0x1D with autoinc, or 0xAD 0xAD without it.
REQ-037 Sample read: pulse sample_valid with sample_in=0x5C, then send 0x0B 0x08 0x00 -> miso byte 3 = 0x5C; a simultaneous sample_valid with 0x11 during the load still yields 0x5C.
REQ-038 Soft reset: write 0x2D=0x08, then send 0x0A 0x1F 0x52 -> soft_rst_pulse high for 1 clk and power_ctl=0x00.
REQ-039 Bad command: send 0x0C 0x2D 0xFF -> cmd_err pulses once and power_ctl is unchanged.
REQ-040 Abort: raise cs after 4 bits of the data byte in 0x0A 0x2D xx -> register unchanged and the next transaction completes normally.
